// File: rtl/bitserial_alu_seq.sv
// ---------------------------------------------------------------------------
// bitserial_alu_seq
//
// Word-level sequencer for a 1-bit bit-serial ALU slice. It accepts a
// parallel request (opcode, a, b) and shifts the operands out LSB-first on
// alu_x/alu_y together with the per-operation control lines. It then
// reassembles the returning alu_sum stream into a WIDTH-bit result and
// captures the final carry/overflow from the slice.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, opcode, a, b request strobe (sampled in IDLE only) and operands
//   busy                high from the accepted start until done
//   done                one-cycle pulse; result/carry/overflow valid from here
//   err                 one-cycle pulse for a start with reserved opcode 3'b111
//   result, carry,      assembled Sum word and final Carry_out/Overflow
//   overflow            (carry/overflow are 0 for logic operations)
//   alu_*  (outputs)    slice drive pins: operand bits, carry-in, end marker,
//                       operand complements and operation selects
//   alu_sum, alu_carry_out, alu_overflow  slice result pins, ALU_LAT stages
//                       behind the drive pins
// ---------------------------------------------------------------------------
module bitserial_alu_seq #(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             alu_x,
  output logic             alu_y,
  output logic             alu_carry_in,
  output logic             alu_end,
  output logic             alu_cmpl_x,
  output logic             alu_cmpl_y,
  output logic             alu_op_xor,
  output logic             alu_op_and,
  output logic             alu_op_arith,
  input  logic             alu_sum,
  input  logic             alu_carry_out,
  input  logic             alu_overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // Control-line bundle for one operation; cin is the bit-0 carry-in.
  typedef struct packed {
    logic arith;
    logic op_xor;
    logic op_and;
    logic cmpl_x;
    logic cmpl_y;
    logic cin;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [2:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      3'b000: c.arith = 1'b1;                                          // ADD
      3'b001: begin c.arith = 1'b1; c.cmpl_y = 1'b1; c.cin = 1'b1; end // a-b
      3'b010: begin c.arith = 1'b1; c.cmpl_x = 1'b1; c.cin = 1'b1; end // b-a
      3'b011: c.op_xor = 1'b1;                                         // XOR
      3'b100: c.op_and = 1'b1;                                         // AND
      3'b101: begin c.op_xor = 1'b1; c.cmpl_y = 1'b1; end              // XNOR
      3'b110: begin c.op_and = 1'b1; c.cmpl_y = 1'b1; end              // ANDN
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t             state;
  ctrl_t              start_ctrl;
  logic [WIDTH-1:0]   sh_x;
  logic [WIDTH-1:0]   sh_y;
  logic [CNT_W-1:0]   bit_cnt;      // index of the next bit to present
  logic               is_arith;
  logic [ALU_LAT-1:0] tag_valid;    // tag pipe, aligned with the slice latency
  logic [ALU_LAT-1:0] tag_last;
  logic               tag_out_valid;
  logic               tag_out_last;

  assign start_ctrl    = decode(opcode);
  assign tag_out_valid = tag_valid[ALU_LAT-1];
  assign tag_out_last  = tag_last[ALU_LAT-1];

  // NOTE: every register here, including the operand shifters and the tag
  // pipe, is cleared by reset; a stale tag would otherwise capture in-flight
  // slice bits of an aborted operation into the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      result       <= '0;
      carry        <= 1'b0;
      overflow     <= 1'b0;
      alu_x        <= 1'b0;
      alu_y        <= 1'b0;
      alu_carry_in <= 1'b0;
      alu_end      <= 1'b0;
      alu_cmpl_x   <= 1'b0;
      alu_cmpl_y   <= 1'b0;
      alu_op_xor   <= 1'b0;
      alu_op_and   <= 1'b0;
      alu_op_arith <= 1'b0;
      sh_x         <= '0;
      sh_y         <= '0;
      bit_cnt      <= '0;
      is_arith     <= 1'b0;
      tag_valid    <= '0;
      tag_last     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read below sees
      // the value from before this edge regardless of statement order. The
      // two defaults make done/err single-cycle pulses.
      done <= 1'b0;
      err  <= 1'b0;

      // A tag enters for each cycle a bit sits on the slice pins; it reaches
      // the end of the pipe exactly when that bit's Sum is on alu_sum.
      for (int i = ALU_LAT - 1; i > 0; i--) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_last[i]  <= tag_last[i-1];
      end
      tag_valid[0] <= (state == ISSUE);
      tag_last[0]  <= (state == ISSUE) && alu_end;

      // Sum bits arrive LSB first; shifting in from the MSB side leaves bit
      // i at result[i] after WIDTH captures.
      if (tag_out_valid) begin
        result <= {alu_sum, result[WIDTH-1:1]};
        if (tag_out_last) begin
          carry    <= is_arith & alu_carry_out;
          overflow <= is_arith & alu_overflow;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (opcode == 3'b111) begin
              err <= 1'b1;
            end else begin
              state        <= ISSUE;
              busy         <= 1'b1;
              is_arith     <= start_ctrl.arith;
              alu_x        <= a[0];
              alu_y        <= b[0];
              sh_x         <= a >> 1;
              sh_y         <= b >> 1;
              alu_carry_in <= start_ctrl.cin;
              alu_end      <= 1'b0;
              alu_cmpl_x   <= start_ctrl.cmpl_x;
              alu_cmpl_y   <= start_ctrl.cmpl_y;
              alu_op_xor   <= start_ctrl.op_xor;
              alu_op_and   <= start_ctrl.op_and;
              alu_op_arith <= start_ctrl.arith;
              bit_cnt      <= CNT_W'(1);
            end
          end
        end
        ISSUE: begin
          if (bit_cnt == CNT_W'(WIDTH)) begin
            state        <= DRAIN;
            alu_x        <= 1'b0;
            alu_y        <= 1'b0;
            alu_carry_in <= 1'b0;
            alu_end      <= 1'b0;
            alu_cmpl_x   <= 1'b0;
            alu_cmpl_y   <= 1'b0;
            alu_op_xor   <= 1'b0;
            alu_op_and   <= 1'b0;
            alu_op_arith <= 1'b0;
          end else begin
            alu_x        <= sh_x[0];
            alu_y        <= sh_y[0];
            sh_x         <= sh_x >> 1;
            sh_y         <= sh_y >> 1;
            alu_carry_in <= 1'b0;
            alu_end      <= (bit_cnt == CNT_W'(WIDTH - 1));
            bit_cnt      <= bit_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (tag_out_valid && tag_out_last) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          // start in this cycle is deliberately not looked at.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
